// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the lab FIFO and stack blocks.
// Optional error flags elsewhere are enabled with FIFO_ERR_FLAGS_EN.
package fifo_pkg;

    localparam int FIFO_DEPTH_DEF = 8;
    localparam int FIFO_WIDTH_DEF = 4;

    // Pointer width for a power-of-two depth.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_queue_if.sv
// Handshake/data bundle between a FIFO and its user.
// Overflow/Underflow signals exist only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_queue_if
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
);

    localparam int CNT_W = ptr_w(FIFO_DEPTH) + 1;

    logic [FIFO_WIDTH-1:0] Data_In;
    logic                  Push;
    logic                  Pop;
    logic [FIFO_WIDTH-1:0] Data_Out;
    logic                  Full;
    logic                  Empty;
    logic [CNT_W-1:0]      Count;
`ifdef FIFO_ERR_FLAGS_EN
    logic                  Overflow;
    logic                  Underflow;
`endif

`ifdef FIFO_ERR_FLAGS_EN
    modport master (
        output Data_In, Push, Pop,
        input  Data_Out, Full, Empty, Count, Overflow, Underflow
    );
    modport slave (
        input  Data_In, Push, Pop,
        output Data_Out, Full, Empty, Count, Overflow, Underflow
    );
`else
    modport master (
        output Data_In, Push, Pop,
        input  Data_Out, Full, Empty, Count
    );
    modport slave (
        input  Data_In, Push, Pop,
        output Data_Out, Full, Empty, Count
    );
`endif

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter: advances by one on Inc, wraps by natural overflow.
module fifo_ptr #(
    parameter int PTR_W = 3
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             Inc,
    output logic [PTR_W-1:0] Ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q + PTR_W'(Inc);
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign Ptr = ptr_q;

endmodule

// File: rtl/fifo_queue.sv
// Synchronous FIFO with registered Data_Out and occupancy count.
// Define FIFO_ERR_FLAGS_EN to add sticky Overflow/Underflow observation flags.
module fifo_queue
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
) (
    input logic         Clk,
    input logic         RstN,
    fifo_queue_if.slave bus
);

    localparam int PTR_W = ptr_w(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [FIFO_WIDTH-1:0] data_out_q;
    logic [FIFO_WIDTH-1:0] data_out_d;
    logic                  full;
    logic                  empty;
    logic                  push_ok;
    logic                  pop_ok;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    // A push into a full FIFO is only legal when a pop frees the head slot in the same edge.
    always_comb begin
        pop_ok     = bus.Pop & ~empty;
        push_ok    = bus.Push & (~full | pop_ok);
        count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        data_out_d = pop_ok ? mem[rd_ptr] : data_out_q;
    end

    fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .Clk  (Clk),
        .RstN (RstN),
        .Inc  (push_ok),
        .Ptr  (wr_ptr)
    );

    fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .Clk  (Clk),
        .RstN (RstN),
        .Inc  (pop_ok),
        .Ptr  (rd_ptr)
    );

    // Storage is deliberately not reset; the pointers and count make stale words unreachable.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.Data_In;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.Data_Out = data_out_q;
    assign bus.Full     = full;
    assign bus.Empty    = empty;
    assign bus.Count    = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic overflow_d;
    logic underflow_q;
    logic underflow_d;

    // Sticky observation only; the accept logic above ignores these.
    always_comb begin
        overflow_d  = overflow_q | (bus.Push & full & ~bus.Pop);
        underflow_d = underflow_q | (bus.Pop & empty);
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.Overflow  = overflow_q;
    assign bus.Underflow = underflow_q;
`endif

endmodule
